// File: rtl/inst_fetch_ctrl.sv
// Fetch sequencer for the dual-issue front end.
// Owns the fetch PC, runs the instruction-memory read handshake, and buffers
// returned instruction pairs in an in-order queue that feeds decode.
// A redirect from branch resolution flushes the queue and restarts fetch.
//
// state   | meaning
// --------+-------------------------------------------------------------
// BOOT    | first cycle after reset, no request issued
// RUN     | requesting pairs at r_pc while the queue has room
// FULL    | queue holds DEPTH pairs, request held off until a pop
// RECOVER | single bubble after a redirect, request dropped
module inst_fetch_ctrl #(
   parameter int                ADDR_W   = 32,
   parameter int                DATA_W   = 32,
   parameter logic [ADDR_W-1:0] RESET_PC = '0,
   parameter int                DEPTH    = 4
) (
   input  logic              clk,
   input  logic              rst,
   output logic [ADDR_W-1:0] inst_address,
   output logic              InstMem_Read,
   input  logic              InstMem_Ready,
   input  logic [DATA_W-1:0] inst1_in,
   input  logic [DATA_W-1:0] inst2_in,
   input  logic              redirect_valid,
   input  logic [ADDR_W-1:0] redirect_pc,
   input  logic              dec_ready,
   output logic              dec_valid,
   output logic [DATA_W-1:0] dec_inst1,
   output logic [DATA_W-1:0] dec_inst2,
   output logic [ADDR_W-1:0] dec_pc,
   output logic [1:0]        fetch_state
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DEPTH - 1);
   localparam logic [ADDR_W-1:0] PAIR_STEP = ADDR_W'(8);

   typedef enum logic [1:0] {
      ST_BOOT    = 2'd0,
      ST_RUN     = 2'd1,
      ST_FULL    = 2'd2,
      ST_RECOVER = 2'd3
   } state_t;

   state_t             r_state;
   state_t             w_state_nxt;
   logic [ADDR_W-1:0]  r_pc;
   logic [PTR_W-1:0]   r_wr_ptr;
   logic [PTR_W-1:0]   r_rd_ptr;
   logic [CNT_W-1:0]   r_count;
   logic [DATA_W-1:0]  r_q_inst1 [DEPTH];
   logic [DATA_W-1:0]  r_q_inst2 [DEPTH];
   logic [ADDR_W-1:0]  r_q_pc    [DEPTH];

   logic               w_read;
   logic               w_dec_valid;
   logic               w_push;
   logic               w_pop;

   assign w_dec_valid = (r_count != '0);
   // A redirect on the same edge discards both the returning pair and any pop.
   assign w_push = w_read && InstMem_Ready && !redirect_valid;
   assign w_pop  = w_dec_valid && dec_ready && !redirect_valid;

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= ST_BOOT;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state and request decode; redirect overrides every state.
   always_comb begin
      w_state_nxt = r_state;
      w_read      = 1'b0;
      case (r_state)
         ST_BOOT: begin
            w_state_nxt = ST_RUN;
         end
         ST_RUN: begin
            w_read = (r_count < FULL_CNT);
            if (w_push && !w_pop && (r_count == LAST_CNT)) begin
               w_state_nxt = ST_FULL;
            end
         end
         ST_FULL: begin
            if (w_pop) begin
               w_state_nxt = ST_RUN;
            end
         end
         ST_RECOVER: begin
            w_state_nxt = ST_RUN;
         end
         default: begin
            w_state_nxt = ST_BOOT;
         end
      endcase
      if (redirect_valid) begin
         w_state_nxt = ST_RECOVER;
      end
   end

   // Fetch PC: jump on redirect, otherwise step one pair per completed transfer.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_pc <= RESET_PC;
      end else if (redirect_valid) begin
         r_pc <= redirect_pc;
      end else if (w_push) begin
         r_pc <= r_pc + PAIR_STEP;
      end
   end

   // Queue pointers and occupancy; flushed by redirect.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else if (redirect_valid) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   // Queue storage; contents are only observed through a valid head entry.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_q_inst1[r_wr_ptr] <= inst1_in;
         r_q_inst2[r_wr_ptr] <= inst2_in;
         r_q_pc[r_wr_ptr]    <= r_pc;
      end
   end

   assign inst_address = r_pc;
   assign InstMem_Read = w_read;
   assign dec_valid    = w_dec_valid;
   assign dec_inst1    = w_dec_valid ? r_q_inst1[r_rd_ptr] : '0;
   assign dec_inst2    = w_dec_valid ? r_q_inst2[r_rd_ptr] : '0;
   assign dec_pc       = w_dec_valid ? r_q_pc[r_rd_ptr]    : '0;
   assign fetch_state  = r_state;

endmodule

// File: tb/tb_inst_fetch_ctrl.sv
// Directed bench for inst_fetch_ctrl with a queue scoreboard of expected pair PCs.
module tb_inst_fetch_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] inst_address;
   logic        InstMem_Read;
   logic        InstMem_Ready;
   logic [31:0] inst1_in;
   logic [31:0] inst2_in;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        dec_ready;
   logic        dec_valid;
   logic [31:0] dec_inst1;
   logic [31:0] dec_inst2;
   logic [31:0] dec_pc;
   logic [1:0]  fetch_state;

   // second instance: wrapping reset PC, zero-wait memory, decode always ready
   logic        rst2;
   logic [31:0] w2_addr;
   logic        w2_read;
   logic        w2_ready;
   logic [31:0] w2_inst1;
   logic [31:0] w2_inst2;
   logic        w2_redir;
   logic [31:0] w2_redir_pc;
   logic        w2_dec_ready;
   logic        w2_dec_valid;
   logic [31:0] w2_dec_inst1;
   logic [31:0] w2_dec_inst2;
   logic [31:0] w2_dec_pc;
   logic [1:0]  w2_state;

   int          n_cmp = 0;
   int          n_err = 0;
   logic [31:0] exp_pc;
   logic [31:0] exp_q [$];

   always #5 clk = ~clk;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return {a[15:0], a[31:16]} ^ 32'h5A5A_0F0F;
   endfunction

   assign inst1_in = mem_word(inst_address);
   assign inst2_in = mem_word(inst_address + 32'd4);
   assign w2_inst1 = mem_word(w2_addr);
   assign w2_inst2 = mem_word(w2_addr + 32'd4);
   assign w2_ready = 1'b1;
   assign w2_redir = 1'b0;
   assign w2_redir_pc = 32'h0;
   assign w2_dec_ready = 1'b1;

   inst_fetch_ctrl #(.ADDR_W(32), .DATA_W(32), .RESET_PC(32'h0), .DEPTH(4)) u_dut (
      .clk(clk), .rst(rst),
      .inst_address(inst_address), .InstMem_Read(InstMem_Read), .InstMem_Ready(InstMem_Ready),
      .inst1_in(inst1_in), .inst2_in(inst2_in),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .dec_ready(dec_ready), .dec_valid(dec_valid),
      .dec_inst1(dec_inst1), .dec_inst2(dec_inst2), .dec_pc(dec_pc),
      .fetch_state(fetch_state)
   );

   inst_fetch_ctrl #(.ADDR_W(32), .DATA_W(32), .RESET_PC(32'hFFFF_FFF8), .DEPTH(4)) u_wrap (
      .clk(clk), .rst(rst2),
      .inst_address(w2_addr), .InstMem_Read(w2_read), .InstMem_Ready(w2_ready),
      .inst1_in(w2_inst1), .inst2_in(w2_inst2),
      .redirect_valid(w2_redir), .redirect_pc(w2_redir_pc),
      .dec_ready(w2_dec_ready), .dec_valid(w2_dec_valid),
      .dec_inst1(w2_dec_inst1), .dec_inst2(w2_dec_inst2), .dec_pc(w2_dec_pc),
      .fetch_state(w2_state)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One clock: pre-edge checks and scoreboard update, then settle after the edge.
   task automatic tick(input logic exp_rd);
      logic        mdl_push;
      logic        mdl_pop;
      logic [31:0] head;
      @(negedge clk);
      check("read", 64'(InstMem_Read), 64'(exp_rd));
      check("dec_valid", 64'(dec_valid), 64'(exp_q.size() != 0));
      if (exp_rd) check("addr", 64'(inst_address), 64'(exp_pc));
      mdl_push = exp_rd && InstMem_Ready && !redirect_valid;
      mdl_pop  = (exp_q.size() != 0) && dec_ready && !redirect_valid;
      if (mdl_pop) begin
         head = exp_q.pop_front();
         check("dec_pc", 64'(dec_pc), 64'(head));
         check("dec_inst1", 64'(dec_inst1), 64'(mem_word(head)));
         check("dec_inst2", 64'(dec_inst2), 64'(mem_word(head + 32'd4)));
      end
      if (redirect_valid) begin
         exp_q.delete();
         exp_pc = redirect_pc;
      end else if (mdl_push) begin
         exp_q.push_back(exp_pc);
         exp_pc = exp_pc + 32'd8;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      #1;
      check("rst_read", 64'(InstMem_Read), 64'(0));
      check("rst_addr", 64'(inst_address), 64'(0));
      check("rst_dec_valid", 64'(dec_valid), 64'(0));
      check("rst_dec_pc", 64'(dec_pc), 64'(0));
      check("rst_dec_inst1", 64'(dec_inst1), 64'(0));
      check("rst_state", 64'(fetch_state), 64'(0));
      exp_q.delete();
      exp_pc = 32'h0;
      @(posedge clk);
      #1;
      rst  = 1'b0;
      rst2 = 1'b0;
   endtask

   initial begin
      rst = 1'b0;
      rst2 = 1'b0;
      InstMem_Ready = 1'b1;
      redirect_valid = 1'b0;
      redirect_pc = 32'h0;
      dec_ready = 1'b1;
      #2 rst2 = 1'b1;

      // streaming with zero-wait memory and decode always ready
      do_reset();
      tick(1'b0);
      check("wrap_read", 64'(w2_read), 64'(1));
      check("wrap_addr0", 64'(w2_addr), 64'(32'hFFFF_FFF8));
      tick(1'b1);
      check("wrap_addr1", 64'(w2_addr), 64'(0));
      check("wrap_dec_pc", 64'(w2_dec_pc), 64'(32'hFFFF_FFF8));
      check("wrap_dec_inst2", 64'(w2_dec_inst2), 64'(mem_word(32'hFFFF_FFFC)));
      tick(1'b1);
      check("wrap_dec_pc1", 64'(w2_dec_pc), 64'(0));
      for (int i = 0; i < 4; i++) tick(1'b1);

      // fill to FULL with decode stalled, then a single pop
      do_reset();
      dec_ready = 1'b0;
      tick(1'b0);
      for (int i = 0; i < 4; i++) tick(1'b1);
      check("full_state", 64'(fetch_state), 64'(2));
      tick(1'b0);
      tick(1'b0);
      dec_ready = 1'b1;
      tick(1'b0);
      dec_ready = 1'b0;
      check("refill_state", 64'(fetch_state), 64'(1));
      tick(1'b1);
      check("refull_state", 64'(fetch_state), 64'(2));

      // drain, then stall the memory at 0x40
      dec_ready = 1'b1;
      tick(1'b0);
      for (int i = 0; i < 3; i++) tick(1'b1);
      InstMem_Ready = 1'b0;
      for (int i = 0; i < 3; i++) tick(1'b1);
      InstMem_Ready = 1'b1;
      tick(1'b1);
      check("post_stall_addr", 64'(inst_address), 64'(32'h48));

      // redirect colliding with a completion at 0x48
      redirect_valid = 1'b1;
      redirect_pc = 32'h1000;
      tick(1'b1);
      redirect_valid = 1'b0;
      check("recover_state", 64'(fetch_state), 64'(3));
      check("recover_read", 64'(InstMem_Read), 64'(0));
      check("recover_empty", 64'(dec_valid), 64'(0));
      tick(1'b0);
      tick(1'b1);
      check("target_valid", 64'(dec_valid), 64'(1));
      check("target_pc", 64'(dec_pc), 64'(32'h1000));

      // asynchronous reset while FULL
      dec_ready = 1'b0;
      for (int i = 0; i < 3; i++) tick(1'b1);
      tick(1'b0);
      check("pre_rst_state", 64'(fetch_state), 64'(2));
      #3 rst = 1'b1;
      #1;
      check("async_dec_valid", 64'(dec_valid), 64'(0));
      check("async_read", 64'(InstMem_Read), 64'(0));
      check("async_state", 64'(fetch_state), 64'(0));
      check("async_dec_inst2", 64'(dec_inst2), 64'(0));
      exp_q.delete();
      exp_pc = 32'h0;
      @(posedge clk);
      #1;
      rst = 1'b0;
      tick(1'b0);
      tick(1'b1);
      dec_ready = 1'b1;
      tick(1'b1);
      tick(1'b1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
